// File: rtl/keypad_hex_entry.sv
// keypad_hex_entry
// Scans a 4x4 hex keypad (Pmod KYPD layout), debounces whole-keypad scans and
// shifts every accepted key into a 32-bit entry word, newest nibble lowest.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous reset, active low
//   clr       synchronous clear of value/digits, active high (level)
//   row[3:0]  keypad rows, active low, asynchronous to clk
//   col[3:0]  keypad column drive, active low, one-hot-low
//   value     entry word, newest digit in [3:0]
//   key_code  code of the last accepted key
//   key_valid one-cycle strobe when a key is accepted
//   digits    digits entered since reset/clr, saturates at 8
module keypad_hex_entry #(
  parameter int SCAN_CYCLES = 100000,
  parameter int DEB_SCANS   = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [31:0] value,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [3:0]  digits
);

  localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int CW = $clog2(DEB_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEB_TARGET = CW'(DEB_SCANS);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CAND   = 3'd1,
    S_ACCEPT = 3'd2,
    S_HELD   = 3'd3,
    S_REL    = 3'd4
  } deb_state_t;

  // Map bit index {col, row} to the printed key legend.
  function automatic logic [3:0] key_lookup(input logic [3:0] bit_idx);
    case (bit_idx)
      4'd0:    key_lookup = 4'h1;
      4'd1:    key_lookup = 4'h4;
      4'd2:    key_lookup = 4'h7;
      4'd3:    key_lookup = 4'h0;
      4'd4:    key_lookup = 4'h2;
      4'd5:    key_lookup = 4'h5;
      4'd6:    key_lookup = 4'h8;
      4'd7:    key_lookup = 4'hF;
      4'd8:    key_lookup = 4'h3;
      4'd9:    key_lookup = 4'h6;
      4'd10:   key_lookup = 4'h9;
      4'd11:   key_lookup = 4'hE;
      4'd12:   key_lookup = 4'hA;
      4'd13:   key_lookup = 4'hB;
      4'd14:   key_lookup = 4'hC;
      4'd15:   key_lookup = 4'hD;
      default: key_lookup = 4'h0;
    endcase
  endfunction

  logic [3:0]    row_meta_r, row_sync_r;
  logic [1:0]    col_idx_r;
  logic [DW-1:0] dwell_r;
  logic [11:0]   map_r;       // columns 0..2; column 3 is read live at scan end
  logic [3:0]    col_r;
  logic          sample_s, scan_end_s;
  logic [15:0]   scan_map_s;
  logic [4:0]    hit_count_s;
  logic [3:0]    hit_idx_s, code_s;
  logic          none_s, single_s;
  deb_state_t    state_r, state_s;
  logic [3:0]    cand_r, cand_s;
  logic [CW-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic [31:0]   value_r;
  logic [3:0]    key_code_r, digits_r;
  logic          key_valid_r;

  assign sample_s   = (dwell_r == DWELL_LAST);
  assign scan_end_s = sample_s && (col_idx_r == 2'd3);
  assign cnt_inc_s  = cnt_r + CNT_ONE;

  // Row synchronizer, column dwell timer and per-column row capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_meta_r <= 4'b1111;
      row_sync_r <= 4'b1111;
      col_idx_r  <= 2'd0;
      dwell_r    <= '0;
      map_r      <= 12'd0;
      col_r      <= 4'b1110;
    end else begin
      row_meta_r <= row;
      row_sync_r <= row_meta_r;
      if (sample_s) begin
        dwell_r   <= '0;
        col_idx_r <= col_idx_r + 2'd1;
        col_r     <= ~(4'b0001 << (col_idx_r + 2'd1));
        case (col_idx_r)
          2'd0:    map_r[3:0]  <= ~row_sync_r;
          2'd1:    map_r[7:4]  <= ~row_sync_r;
          2'd2:    map_r[11:8] <= ~row_sync_r;
          default: map_r       <= map_r;
        endcase
      end else begin
        dwell_r <= dwell_r + DW'(1);
      end
    end
  end

  // Full-scan map (column 3 taken from the sync flops on its sample cycle) and
  // classification into NONE / SINGLE(code) / MULTI.
  always_comb begin
    scan_map_s  = {~row_sync_r, map_r};
    hit_count_s = 5'd0;
    hit_idx_s   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      hit_count_s = hit_count_s + {4'd0, scan_map_s[i]};
      if (scan_map_s[i]) begin
        hit_idx_s = 4'(i);
      end else begin
        hit_idx_s = hit_idx_s;
      end
    end
    none_s   = (hit_count_s == 5'd0);
    single_s = (hit_count_s == 5'd1);
    code_s   = key_lookup(hit_idx_s);
  end

  // Debounce state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= S_IDLE;
      cand_r  <= 4'd0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cand_r  <= cand_s;
      cnt_r   <= cnt_s;
    end
  end

  // Debounce next-state: only scan-end cycles move the press/release counters.
  always_comb begin
    state_s = state_r;
    cand_s  = cand_r;
    cnt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (scan_end_s && single_s) begin
          cand_s  = code_s;
          cnt_s   = CNT_ONE;
          state_s = (CNT_ONE >= DEB_TARGET) ? S_ACCEPT : S_CAND;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CAND: begin
        if (!scan_end_s) begin
          state_s = S_CAND;
        end else if (single_s && (code_s == cand_r)) begin
          cnt_s   = cnt_inc_s;
          state_s = (cnt_inc_s >= DEB_TARGET) ? S_ACCEPT : S_CAND;
        end else if (single_s) begin
          cand_s = code_s;
          cnt_s  = CNT_ONE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ACCEPT: state_s = S_HELD;
      S_HELD: begin
        if (scan_end_s && none_s) begin
          cnt_s   = CNT_ONE;
          state_s = (CNT_ONE >= DEB_TARGET) ? S_IDLE : S_REL;
        end else begin
          state_s = S_HELD;
        end
      end
      S_REL: begin
        if (!scan_end_s) begin
          state_s = S_REL;
        end else if (none_s) begin
          cnt_s   = cnt_inc_s;
          state_s = (cnt_inc_s >= DEB_TARGET) ? S_IDLE : S_REL;
        end else begin
          state_s = S_HELD;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Output registers: strobe/code are loaded on entry to ACCEPT so they are
  // visible during the ACCEPT cycle; the entry word shifts as ACCEPT ends,
  // and clr overrides that shift.
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_valid_r <= 1'b0;
      key_code_r  <= 4'd0;
      value_r     <= 32'd0;
      digits_r    <= 4'd0;
    end else begin
      key_valid_r <= (state_s == S_ACCEPT);
      if (state_s == S_ACCEPT) begin
        key_code_r <= cand_s;
      end else begin
        key_code_r <= key_code_r;
      end
      if (clr) begin
        value_r  <= 32'd0;
        digits_r <= 4'd0;
      end else if (state_r == S_ACCEPT) begin
        value_r  <= {value_r[27:0], cand_r};
        digits_r <= (digits_r == 4'd8) ? 4'd8 : (digits_r + 4'd1);
      end else begin
        value_r  <= value_r;
        digits_r <= digits_r;
      end
    end
  end

  assign col       = col_r;
  assign value     = value_r;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign digits    = digits_r;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// tb_keypad_hex_entry
// Drives a modelled keypad (pressed-key set pulls rows low under the driven
// column) and checks the DUT cycle by cycle against a scan-level reference:
// runs of identical single-key scans arm an acceptance, runs of empty scans
// re-arm after a press.
module tb_keypad_hex_entry;

  localparam int SC       = 8;
  localparam int DEB      = 3;
  localparam int SCAN_LEN = 4 * SC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [31:0] value;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [3:0]  digits;
  logic [15:0] keys = 16'h0000;   // bit col*4+row = key pressed

  int total = 0;
  int bad   = 0;

  // legend for bit index col*4+row
  logic [3:0] keymap [16] = '{4'h1, 4'h4, 4'h7, 4'h0, 4'h2, 4'h5, 4'h8, 4'hF,
                              4'h3, 4'h6, 4'h9, 4'hE, 4'hA, 4'hB, 4'hC, 4'hD};

  // reference state
  bit          armed;
  int          run_len, none_len;
  logic [3:0]  run_key;
  bit          pending;
  logic [3:0]  pend_code;
  logic [31:0] exp_value;
  int          exp_digits;
  logic [3:0]  exp_code;
  int          pulses, scan_no, pulse_scan;

  always #5 clk = ~clk;

  keypad_hex_entry #(.SCAN_CYCLES(SC), .DEB_SCANS(DEB)) dut (
    .clk(clk), .rst(rst), .clr(clr), .row(row), .col(col),
    .value(value), .key_code(key_code), .key_valid(key_valid), .digits(digits)
  );

  // keypad: a pressed key pulls its row low while its column is driven low
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && keys[c*4+r]) row[r] = 1'b0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] key_mask(input logic [3:0] k);
    logic [15:0] m = 16'h0000;
    for (int i = 0; i < 16; i++)
      if (keymap[i] == k) m = 16'h0001 << i;
    return m;
  endfunction

  task automatic model_reset();
    armed = 1'b1; run_len = 0; none_len = 0; run_key = 4'h0;
    pending = 1'b0; pend_code = 4'h0;
    exp_value = 32'd0; exp_digits = 0; exp_code = 4'h0;
  endtask

  // scan-level debounce reference, applied once per completed scan
  task automatic scan_done(input logic [15:0] m);
    int n = $countones(m);
    logic [3:0] k = 4'h0;
    for (int i = 0; i < 16; i++) if (m[i]) k = keymap[i];
    if (armed) begin
      if (n == 1) begin
        if (run_len > 0 && run_key == k) run_len++;
        else begin run_key = k; run_len = 1; end
        if (run_len == DEB) begin
          pending = 1'b1; pend_code = k; armed = 1'b0; none_len = 0; run_len = 0;
        end
      end else begin
        run_len = 0;
      end
    end else begin
      if (n == 0) begin
        none_len++;
        if (none_len == DEB) begin armed = 1'b1; none_len = 0; run_len = 0; end
      end else begin
        none_len = 0;
      end
    end
  endtask

  task automatic apply_reset(input int n);
    logic [3:0] exp_col = 4'b1110;
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    check_eq("rst_col", col, exp_col);
    check_eq("rst_value", value, 32'd0);
    check_eq("rst_digits", digits, 32'd0);
    check_eq("rst_kvalid", key_valid, 32'd0);
    check_eq("rst_kcode", key_code, 32'd0);
    rst = 1'b1;
    model_reset();
  endtask

  // one full scan with key set m; optional clr pulse in its first cycle
  task automatic run_scan(input logic [15:0] m, input bit do_clr);
    logic [3:0] exp_col;
    for (int c = 0; c < SCAN_LEN; c++) begin
      @(negedge clk);
      if (c == 0) begin keys = m; clr = do_clr; end
      if (c == 1) clr = 1'b0;
      exp_col = ~(4'b0001 << (c / SC));
      check_eq("col", col, exp_col);
      check_eq("key_valid", key_valid, {31'd0, (c == 0) && pending});
      if (key_valid) begin pulses++; pulse_scan = scan_no; end
      if (c == 0) begin
        if (pending) exp_code = pend_code;
        if (do_clr) begin
          exp_value = 32'd0; exp_digits = 0;
        end else if (pending) begin
          exp_value = {exp_value[27:0], pend_code};
          exp_digits = (exp_digits < 8) ? exp_digits + 1 : 8;
        end
        pending = 1'b0;
      end
      if (c == 4) begin
        check_eq("value", value, exp_value);
        check_eq("digits", digits, exp_digits);
        check_eq("key_code", key_code, {28'd0, exp_code});
      end
    end
    scan_done(m);
    scan_no++;
  endtask

  task automatic press_release(input logic [3:0] k);
    repeat (3) run_scan(key_mask(k), 1'b0);
    repeat (3) run_scan(16'h0000, 1'b0);
  endtask

  initial begin
    int p0, s0, len, a, b;
    logic [15:0] m;
    logic [3:0] entry [9] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    pulses = 0; scan_no = 0; pulse_scan = -1;
    model_reset();

    // reset, then idle scans exercise column stepping and wrap
    apply_reset(5);
    repeat (2) run_scan(16'h0000, 1'b0);

    // single press of '5' held for 10 scans
    p0 = pulses; s0 = scan_no;
    repeat (10) run_scan(key_mask(4'h5), 1'b0);
    check_eq("single_pulses", pulses - p0, 1);
    check_eq("single_latency", pulse_scan - s0, 3);
    check_eq("single_code", key_code, 32'h5);
    check_eq("single_value", value, 32'h0000_0005);
    check_eq("single_digits", digits, 32'd1);
    repeat (3) run_scan(16'h0000, 1'b0);

    // bounce: 2 scans, gap, 3 scans -> one pulse
    p0 = pulses;
    repeat (2) run_scan(key_mask(4'h5), 1'b0);
    run_scan(16'h0000, 1'b0);
    repeat (3) run_scan(key_mask(4'h5), 1'b0);
    run_scan(16'h0000, 1'b0);
    check_eq("bounce_pulses", pulses - p0, 1);
    // short release then re-press: no new pulse
    run_scan(16'h0000, 1'b0);
    p0 = pulses;
    repeat (4) run_scan(key_mask(4'h5), 1'b0);
    check_eq("early_repress", pulses - p0, 0);
    repeat (3) run_scan(16'h0000, 1'b0);
    repeat (3) run_scan(key_mask(4'h5), 1'b0);
    run_scan(16'h0000, 1'b0);
    check_eq("late_repress", pulses - p0, 1);
    repeat (2) run_scan(16'h0000, 1'b0);

    // entry sequence with shift-out on the 9th digit
    run_scan(16'h0000, 1'b1);
    for (int i = 0; i < 8; i++) press_release(entry[i]);
    check_eq("entry8_value", value, 32'h123A_BCDE);
    check_eq("entry8_digits", digits, 32'd8);
    press_release(entry[8]);
    check_eq("entry9_value", value, 32'h23AB_CDEF);
    check_eq("entry9_digits", digits, 32'd8);

    // two keys together are never accepted
    p0 = pulses;
    repeat (10) run_scan(key_mask(4'h1) | key_mask(4'h2), 1'b0);
    repeat (3) run_scan(16'h0000, 1'b0);
    check_eq("multi_pulses", pulses - p0, 0);

    // '7' then '0' with clr in the ACCEPT cycle of '0'
    run_scan(16'h0000, 1'b1);
    press_release(4'h7);
    check_eq("seven_value", value, 32'h7);
    p0 = pulses;
    repeat (3) run_scan(key_mask(4'h0), 1'b0);
    run_scan(key_mask(4'h0), 1'b1);
    check_eq("clr_pulse", pulses - p0, 1);
    check_eq("clr_value", value, 32'd0);
    check_eq("clr_digits", digits, 32'd0);
    check_eq("clr_code", key_code, 32'h0);
    repeat (3) run_scan(16'h0000, 1'b0);

    // reset while 'D' is held
    repeat (2) run_scan(key_mask(4'hD), 1'b0);
    apply_reset(1);
    p0 = pulses; s0 = scan_no;
    repeat (4) run_scan(key_mask(4'hD), 1'b0);
    check_eq("rstmid_pulses", pulses - p0, 1);
    check_eq("rstmid_latency", pulse_scan - s0, 3);
    check_eq("rstmid_value", value, 32'h0000_000D);
    repeat (3) run_scan(16'h0000, 1'b0);

    // randomized key patterns, checked cycle by cycle against the reference
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 2))
        0: m = 16'h0000;
        1: m = 16'h0001 << $urandom_range(0, 15);
        default: begin
          a = $urandom_range(0, 15);
          b = (a + $urandom_range(1, 15)) % 16;
          m = (16'h0001 << a) | (16'h0001 << b);
        end
      endcase
      len = $urandom_range(1, 5);
      for (int j = 0; j < len; j++) run_scan(m, ($urandom_range(0, 7) == 0));
    end
    repeat (4) run_scan(16'h0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
